// File: rtl/tnoc_input_route_fifo.sv
// rtl/tnoc_input_route_fifo.sv - input-port flit FIFO with XY route computation and framing check
//
// Purpose: buffers flits from the error-checking stage, computes a one-hot XY
// output route from the head flit's destination, holds it for the packet and
// flags input framing violations.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   own_id_x, own_id_y              this router's coordinates (quasi-static)
//   flit_in_*                       upstream flit (valid/ready handshake)
//   flit_out_*                      buffered flit at FIFO head (valid/ready)
//   route, route_valid              one-hot {local, Y-, Y+, X-, X+} for output packet
//   occupancy                       current entry count
//   framing_error                   sticky input framing violation

module tnoc_input_route_fifo #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 64,
    parameter int ID_X_WIDTH = 3,
    parameter int ID_Y_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ID_X_WIDTH-1:0]   own_id_x,
    input  logic [ID_Y_WIDTH-1:0]   own_id_y,
    input  logic                    flit_in_valid,
    output logic                    flit_in_ready,
    input  logic                    flit_in_head,
    input  logic                    flit_in_tail,
    input  logic [ID_X_WIDTH-1:0]   flit_in_dest_x,
    input  logic [ID_Y_WIDTH-1:0]   flit_in_dest_y,
    input  logic [DATA_WIDTH-1:0]   flit_in_data,
    output logic                    flit_out_valid,
    input  logic                    flit_out_ready,
    output logic                    flit_out_head,
    output logic                    flit_out_tail,
    output logic [DATA_WIDTH-1:0]   flit_out_data,
    output logic [4:0]              route,
    output logic                    route_valid,
    output logic [$clog2(DEPTH):0]  occupancy,
    output logic                    framing_error
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic                  head_q [DEPTH];
    logic                  tail_q [DEPTH];
    logic [ID_X_WIDTH-1:0] dx_q   [DEPTH];
    logic [ID_Y_WIDTH-1:0] dy_q   [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   occ_q, occ_d;
    logic          in_packet_q, in_packet_d;
    logic          framing_error_q, framing_error_d;
    state_t        state_q;
    logic [4:0]    route_latched_q;
    logic [4:0]    route_calc;
    logic          push, pop;

    // Handshake outputs depend only on registered occupancy, never on the
    // opposite side's valid/ready.
    assign flit_in_ready  = (occ_q != FULL);
    assign flit_out_valid = (occ_q != '0);
    assign push           = flit_in_valid && flit_in_ready;
    assign pop            = flit_out_valid && flit_out_ready;

    assign flit_out_head  = head_q[rd_ptr_q];
    assign flit_out_tail  = tail_q[rd_ptr_q];
    assign flit_out_data  = data_q[rd_ptr_q];
    assign occupancy      = occ_q;
    assign framing_error  = framing_error_q;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        occ_d    = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + (PW+1)'(1);
            2'b01:   occ_d = occ_q - (PW+1)'(1);
            default: occ_d = occ_q;
        endcase
    end

    // A push is a framing violation exactly when its head flag matches the
    // in-packet state: head inside a packet, or body/tail outside one.
    always_comb begin
        in_packet_d     = in_packet_q;
        framing_error_d = framing_error_q;
        if (push) begin
            if (flit_in_head == in_packet_q)
                framing_error_d = 1'b1;
            if (flit_in_tail)
                in_packet_d = 1'b0;
            else if (flit_in_head)
                in_packet_d = 1'b1;
        end
    end

    // XY dimension-order route from the stored destination of the head entry.
    always_comb begin
        route_calc = 5'b10000;
        if (dx_q[rd_ptr_q] > own_id_x)
            route_calc = 5'b00001;
        else if (dx_q[rd_ptr_q] < own_id_x)
            route_calc = 5'b00010;
        else if (dy_q[rd_ptr_q] > own_id_y)
            route_calc = 5'b00100;
        else if (dy_q[rd_ptr_q] < own_id_y)
            route_calc = 5'b01000;
    end

    // In IDLE the route is shown the same cycle the head appears; in ACTIVE
    // the latched value holds for the rest of the packet.
    always_comb begin
        if (state_q == ACTIVE) begin
            route_valid = 1'b1;
            route       = route_latched_q;
        end else begin
            route_valid = flit_out_valid && flit_out_head;
            route       = route_valid ? route_calc : 5'b00000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            occ_q           <= '0;
            in_packet_q     <= 1'b0;
            framing_error_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                head_q[i] <= 1'b0;
                tail_q[i] <= 1'b0;
                dx_q[i]   <= '0;
                dy_q[i]   <= '0;
            end
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            occ_q           <= occ_d;
            in_packet_q     <= in_packet_d;
            framing_error_q <= framing_error_d;
            if (push) begin
                data_q[wr_ptr_q] <= flit_in_data;
                head_q[wr_ptr_q] <= flit_in_head;
                tail_q[wr_ptr_q] <= flit_in_tail;
                dx_q[wr_ptr_q]   <= flit_in_dest_x;
                dy_q[wr_ptr_q]   <= flit_in_dest_y;
            end
        end
    end

    // Route FSM. A single-flit packet popped in the cycle it appears never
    // leaves IDLE, so the following head is routed straight away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            route_latched_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (flit_out_valid && flit_out_head) begin
                        route_latched_q <= route_calc;
                        if (!(pop && flit_out_tail))
                            state_q <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (pop && flit_out_tail)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tnoc_input_route_fifo.sv
// tb/tb_tnoc_input_route_fifo.sv - directed vector bench for tnoc_input_route_fifo

module tb_tnoc_input_route_fifo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  own_id_x = 3'd1;
    logic [2:0]  own_id_y = 3'd1;
    logic        flit_in_valid = 1'b0;
    logic        flit_in_ready;
    logic        flit_in_head = 1'b0;
    logic        flit_in_tail = 1'b0;
    logic [2:0]  flit_in_dest_x = '0;
    logic [2:0]  flit_in_dest_y = '0;
    logic [63:0] flit_in_data = '0;
    logic        flit_out_valid;
    logic        flit_out_ready = 1'b0;
    logic        flit_out_head;
    logic        flit_out_tail;
    logic [63:0] flit_out_data;
    logic [4:0]  route;
    logic        route_valid;
    logic [2:0]  occupancy;
    logic        framing_error;

    int n_vec  = 0;
    int n_miss = 0;

    tnoc_input_route_fifo #(
        .DEPTH(4), .DATA_WIDTH(64), .ID_X_WIDTH(3), .ID_Y_WIDTH(3)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .own_id_x(own_id_x), .own_id_y(own_id_y),
        .flit_in_valid(flit_in_valid), .flit_in_ready(flit_in_ready),
        .flit_in_head(flit_in_head), .flit_in_tail(flit_in_tail),
        .flit_in_dest_x(flit_in_dest_x), .flit_in_dest_y(flit_in_dest_y),
        .flit_in_data(flit_in_data),
        .flit_out_valid(flit_out_valid), .flit_out_ready(flit_out_ready),
        .flit_out_head(flit_out_head), .flit_out_tail(flit_out_tail),
        .flit_out_data(flit_out_data),
        .route(route), .route_valid(route_valid),
        .occupancy(occupancy), .framing_error(framing_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv, ih, it;
        logic [2:0]  dx, dy;
        logic [63:0] d;
        logic        ordy;
        logic        e_ov, e_ir;
        logic [4:0]  e_rt;
        logic        e_rv;
        logic [2:0]  e_occ;
        logic [63:0] e_d;
        logic        e_err;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(logic iv, logic ih, logic it, logic [2:0] dx, logic [2:0] dy,
                                logic [63:0] d, logic ordy, logic e_ov, logic e_ir,
                                logic [4:0] e_rt, logic e_rv, logic [2:0] e_occ,
                                logic [63:0] e_d, logic e_err);
        vec_t v;
        v.iv = iv; v.ih = ih; v.it = it; v.dx = dx; v.dy = dy; v.d = d; v.ordy = ordy;
        v.e_ov = e_ov; v.e_ir = e_ir; v.e_rt = e_rt; v.e_rv = e_rv;
        v.e_occ = e_occ; v.e_d = e_d; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic ih, input logic it, input logic [2:0] dx,
                         input logic [2:0] dy, input logic [63:0] d, input logic ordy);
        flit_in_valid  = iv;
        flit_in_head   = ih;
        flit_in_tail   = it;
        flit_in_dest_x = dx;
        flit_in_dest_y = dy;
        flit_in_data   = d;
        flit_out_ready = ordy;
    endtask

    initial begin
        // Expected values describe the state seen at the negedge on which the
        // row's inputs are applied (outputs depend only on registered state).
        vecs[0]  = mk(0,0,0,0,0,64'h0,  0, 0,1,5'b00000,0,0,64'h0, 0);
        vecs[1]  = mk(1,1,1,3,1,64'hA1, 0, 0,1,5'b00000,0,0,64'h0, 0);
        vecs[2]  = mk(0,0,0,0,0,64'h0,  1, 1,1,5'b00001,1,1,64'hA1,0);
        vecs[3]  = mk(1,1,0,1,0,64'hB0, 0, 0,1,5'b00000,0,0,64'h0, 0);
        vecs[4]  = mk(1,0,0,0,0,64'hB1, 0, 1,1,5'b01000,1,1,64'hB0,0);
        vecs[5]  = mk(1,0,1,0,0,64'hB2, 0, 1,1,5'b01000,1,2,64'hB0,0);
        vecs[6]  = mk(0,0,0,0,0,64'h0,  1, 1,1,5'b01000,1,3,64'hB0,0);
        vecs[7]  = mk(0,0,0,0,0,64'h0,  1, 1,1,5'b01000,1,2,64'hB1,0);
        vecs[8]  = mk(0,0,0,0,0,64'h0,  1, 1,1,5'b01000,1,1,64'hB2,0);
        vecs[9]  = mk(0,0,0,0,0,64'h0,  0, 0,1,5'b00000,0,0,64'h0, 0);
        vecs[10] = mk(1,1,1,1,1,64'hC0, 0, 0,1,5'b00000,0,0,64'h0, 0);
        vecs[11] = mk(1,1,1,0,2,64'hC1, 0, 1,1,5'b10000,1,1,64'hC0,0);
        vecs[12] = mk(1,1,1,1,3,64'hC2, 0, 1,1,5'b10000,1,2,64'hC0,0);
        vecs[13] = mk(1,1,1,1,1,64'hC3, 0, 1,1,5'b10000,1,3,64'hC0,0);
        vecs[14] = mk(1,1,1,2,2,64'hC4, 1, 1,0,5'b10000,1,4,64'hC0,0);
        vecs[15] = mk(0,0,0,0,0,64'h0,  0, 1,1,5'b00010,1,3,64'hC1,0);
        vecs[16] = mk(0,0,0,0,0,64'h0,  1, 1,1,5'b00010,1,3,64'hC1,0);
        vecs[17] = mk(0,0,0,0,0,64'h0,  1, 1,1,5'b00100,1,2,64'hC2,0);
        vecs[18] = mk(0,0,0,0,0,64'h0,  1, 1,1,5'b10000,1,1,64'hC3,0);
        vecs[19] = mk(0,0,0,0,0,64'h0,  0, 0,1,5'b00000,0,0,64'h0, 0);

        // Reset state while held in reset
        #2;
        chk("rst_occ", occupancy, 0);
        chk("rst_ov", flit_out_valid, 0);
        chk("rst_rv", route_valid, 0);
        chk("rst_route", route, 0);
        chk("rst_err", framing_error, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(vecs[i].iv, vecs[i].ih, vecs[i].it, vecs[i].dx, vecs[i].dy, vecs[i].d, vecs[i].ordy);
            chk($sformatf("v%0d_ov", i), flit_out_valid, vecs[i].e_ov);
            chk($sformatf("v%0d_ir", i), flit_in_ready, vecs[i].e_ir);
            chk($sformatf("v%0d_route", i), route, vecs[i].e_rt);
            chk($sformatf("v%0d_rv", i), route_valid, vecs[i].e_rv);
            chk($sformatf("v%0d_occ", i), occupancy, vecs[i].e_occ);
            chk($sformatf("v%0d_err", i), framing_error, vecs[i].e_err);
            if (vecs[i].e_ov)
                chk($sformatf("v%0d_data", i), flit_out_data, vecs[i].e_d);
        end

        // Continuous push/pop of 20 single-flit packets across pointer wrap
        @(negedge clk);
        drive(1, 1, 1, 3, 1, 64'hD000, 0);
        chk("wrap_start_occ", occupancy, 0);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            drive(i < 20, 1, 1, 3, 1, 64'hD000 + 64'(i), 1);
            chk($sformatf("wrap%0d_occ", i), occupancy, 1);
            chk($sformatf("wrap%0d_data", i), flit_out_data, 64'hD000 + 64'(i - 1));
            chk($sformatf("wrap%0d_route", i), route, 5'b00001);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("wrap_end_occ", occupancy, 0);

        // Framing: head, body, head without tail
        @(negedge clk);
        drive(1, 1, 0, 2, 1, 64'hE0, 0);
        chk("frm_err0", framing_error, 0);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 64'hE1, 0);
        chk("frm_err1", framing_error, 0);
        @(negedge clk);
        drive(1, 1, 0, 2, 1, 64'hE2, 0);
        chk("frm_err2", framing_error, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("frm_err3", framing_error, 1);
        chk("frm_occ3", occupancy, 3);
        @(negedge clk);
        chk("frm_sticky", framing_error, 1);
        chk("frm_rv", route_valid, 1);
        chk("frm_route", route, 5'b00001);

        // Asynchronous reset mid-packet, away from any clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("arst_occ", occupancy, 0);
        chk("arst_ov", flit_out_valid, 0);
        chk("arst_rv", route_valid, 0);
        chk("arst_route", route, 0);
        chk("arst_err", framing_error, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ir", flit_in_ready, 1);
        chk("post_rst_occ", occupancy, 0);

        // Non-head flit pushed outside a packet
        drive(1, 0, 1, 0, 0, 64'hF0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("orphan_err", framing_error, 1);
        chk("orphan_occ", occupancy, 1);
        chk("orphan_rv", route_valid, 0);
        chk("orphan_data", flit_out_data, 64'hF0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/tnoc_input_route_fifo.md
Name: tnoc_input_route_fifo

Overview:
- Flit buffer and XY route computer that sits directly downstream of the router's error-checking stage, one instance per input port and virtual channel.
- Stores incoming flits in a FIFO and computes a one-hot output-port route from the head flit's destination ID.
- Holds that route for the whole packet and presents buffered flits plus the route to the switch allocator / crossbar.
- Also flags packet-framing violations on its input.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- DATA_WIDTH, 64, flit payload width excluding head/tail flags.
- ID_X_WIDTH, 3, destination/own X coordinate width.
- ID_Y_WIDTH, 3, destination/own Y coordinate width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- own_id_x  in  ID_X_WIDTH  this router's X; quasi-static
- own_id_y  in  ID_Y_WIDTH  this router's Y; quasi-static
- flit_in_valid  in  1  upstream flit valid
- flit_in_ready  out  1  FIFO can accept
- flit_in_head  in  1  head-flit flag
- flit_in_tail  in  1  tail-flit flag; head and tail both set means single-flit packet
- flit_in_dest_x  in  ID_X_WIDTH  destination X; meaningful on head flit only
- flit_in_dest_y  in  ID_Y_WIDTH  destination Y; meaningful on head flit only
- flit_in_data  in  DATA_WIDTH  payload
- flit_out_valid  out  1  buffered flit available
- flit_out_ready  in  1  downstream accepts
- flit_out_head  out  1  head flag of the flit at the FIFO head
- flit_out_tail  out  1  tail flag of the flit at the FIFO head
- flit_out_data  out  DATA_WIDTH  payload of the flit at the FIFO head
- route  out  5  one-hot {local, Y-, Y+, X-, X+}; bit0 = X+
- route_valid  out  1  route is valid for the current output packet
- occupancy  out  $clog2(DEPTH)+1  current entry count
- framing_error  out  1  sticky input-framing violation flag

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low. All state is cleared on reset.
- Reset values: occupancy=0, flit_out_valid=0, route=0, route_valid=0, framing_error=0. flit_in_ready=1 one cycle after reset release.
- Reset mid-packet: all buffered flits and the latched route are discarded. No partial state survives.
- Push: occurs when flit_in_valid && flit_in_ready.
  - flit_in_ready = (occupancy != DEPTH), derived combinationally from registered occupancy.
  - No combinational valid→ready path.
- Pop: occurs when flit_out_valid && flit_out_ready.
  - flit_out_valid = (occupancy != 0).
  - Output fields come straight from the read-pointer entry.
- Latency: a flit pushed into an empty FIFO appears at the output on the next cycle. There is no fall-through.
- Push and pop in the same cycle: occupancy unchanged; both pointers advance.
  - When full, push is blocked regardless of a same-cycle pop; flit_in_ready depends only on registered occupancy.
- Pointers: log2(DEPTH) bits, wrapping naturally. Occupancy never exceeds DEPTH and never underflows.
- Route state machine, two states:
  - IDLE to ACTIVE: when flit_out_valid && flit_out_head.
    - route is computed combinationally from the head entry's stored dest X/Y and own_id, and registered into route_latched.
    - route and route_valid are driven combinationally in the same cycle the head appears (route = computed value in IDLE, latched value in ACTIVE).
  - ACTIVE to IDLE: on pop of a flit with tail=1.
  - Single-flit packet (head=tail=1): route_valid=1 for the cycle it is presented, then IDLE after the pop.
  - A head and tail popped back-to-back: the next head's route is presented in the cycle following the tail pop.
- XY routing:
  - dest_x > own_x → X+; dest_x < own_x → X-.
  - Otherwise dest_y > own_y → Y+; dest_y < own_y → Y-.
  - Otherwise local.
  - Comparison is unsigned. Exactly one route bit is set whenever route_valid=1.
- Framing check on the input side:
  - An in_packet flag sets on a push of head without tail and clears on a push with tail.
  - framing_error is set if either occurs:
    - a head is pushed while in_packet=1;
    - a non-head flit is pushed while in_packet=0.
  - The offending flit is still stored. framing_error clears only on reset.

Test Plan:
- own=(1,1); single-flit packet dest=(3,1) pushed into empty FIFO → flit_out_valid=1 next cycle, route=5'b00001, route_valid=1, occupancy=1.
- 3-flit packet dest=(1,0), flit_out_ready=0 → route=5'b01000 held steady for 3 pops when ready rises; route_valid=0 after tail pop.
- DEPTH=4; push 4 flits with ready=0 → flit_in_ready=0, occupancy=4; push and pop asserted together → no push accepted, occupancy=3, flit_in_ready=1 next cycle.
- Continuous push and pop of 20 single-flit packets → data order preserved across pointer wrap; occupancy stays 1.
- Head, body, then head pushed without a tail → framing_error=1 after the second head; it stays 1 until rst_n pulses low.
- Assert rst_n low mid-packet with occupancy=3 → occupancy=0, flit_out_valid=0, route_valid=0 immediately (asynchronous).
